// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, buffer entry and reset constants.
// Used by the fetch unit and its instruction buffer.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        KILL
    } ifu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] pc_align(
        input logic [XLEN-1:0] addr
    );
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// One-entry fetch output buffer holding {inst, pc} for the decoder.
// Flush beats load, load beats consume; load and consume never coincide.
module ifu_inst_buf
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            consume_i,
    input  logic            flush_i,
    input  ifu_entry_t      entry_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o
);

    logic       valid_q;
    logic       valid_d;
    ifu_entry_t entry_q;
    ifu_entry_t entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = entry_q.inst;
    assign pc_o    = entry_q.pc;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: pc register, request FSM, redirect handling.
// Define IFU_PERF_CNT_EN to add fetch/stall performance counters.
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            IFU_stall,
    input  logic            dnpc_flag,
    input  logic [XLEN-1:0] dnpc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            IFU_valid,
    input  logic            IDU_ready,
    output logic [XLEN-1:0] IFU_inst,
    output logic [XLEN-1:0] IFU_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
`endif
);

    ifu_state_t      state_q;
    ifu_state_t      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            consume;
    logic            can_issue;
    logic            req_fire;
    logic            buf_load;
    ifu_entry_t      rsp_entry;

    assign consume   = IFU_valid & IDU_ready & ~IFU_stall;
    // Issue only when the buffer will have room for the answer.
    assign can_issue = ~IFU_valid | consume;
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign rsp_entry = '{inst: imem_rsp_data, pc: pc_q};

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imem_req_valid = 1'b0;
        buf_load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req_valid = can_issue;
                if (dnpc_flag) begin
                    state_d = req_fire ? KILL : IDLE;
                end else if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dnpc_flag) begin
                    state_d = imem_rsp_valid ? REQ : KILL;
                end else if (imem_rsp_valid) begin
                    buf_load = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = REQ;
                end
            end
            KILL: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (dnpc_flag) begin
            pc_d = pc_align(dnpc);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_req_addr = pc_q;

    ifu_inst_buf u_buf (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (buf_load),
        .consume_i (consume),
        .flush_i   (dnpc_flag),
        .entry_i   (rsp_entry),
        .valid_o   (IFU_valid),
        .inst_o    (IFU_inst),
        .pc_o      (IFU_pc)
    );

`ifdef IFU_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (buf_load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (IFU_stall & IFU_valid) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch with a transaction-level
// model of the fetch stream plus directed scenarios with literal values.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        IFU_stall = 1'b0;
    logic        dnpc_flag = 1'b0;
    logic [31:0] dnpc = '0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        IDU_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        IFU_valid;
    logic [31:0] IFU_inst;
    logic [31:0] IFU_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ifu_fetch #(.RESET_PC(RPC)) dut (
        .clock          (clock),
        .reset          (reset),
        .IFU_stall      (IFU_stall),
        .dnpc_flag      (dnpc_flag),
        .dnpc           (dnpc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IFU_valid      (IFU_valid),
        .IDU_ready      (IDU_ready),
        .IFU_inst       (IFU_inst),
        .IFU_pc         (IFU_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // stimulus knobs, applied at the next step
    logic        k_reset = 1'b1;
    logic        k_stall = 1'b0;
    logic        k_idu = 1'b0;
    logic        k_rdy = 1'b0;
    logic        k_redir = 1'b0;
    logic [31:0] k_dnpc = '0;
    logic        k_inject = 1'b0;
    int          k_lat = 1;

    // behavioural model of the fetch stream
    logic        armed = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_inst = '0;
    logic [31:0] npc = RPC;
    logic        os_active = 1'b0;
    logic        os_killed = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_stall = '0;

    logic [31:0] acc_q[$];
    logic [31:0] del_q[$];
    int          cyc = 0;
    int          rst_rel = 0;
    int          first_req_cyc = -1;
    int          first_rsp_cyc = -1;
    int          first_val_cyc = -1;
    int          idle_cyc = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic acc;
        logic cons;
        logic load;
        @(negedge clock);
        cyc++;
        if (armed) begin
            chk("ifu_valid", {31'b0, IFU_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("ifu_pc", IFU_pc, m_pc);
                chk("ifu_inst", IFU_inst, m_inst);
            end
`ifdef IFU_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_cnt, m_fetch);
            chk("perf_stall", perf_stall_cnt, m_stall);
`endif
            if (IFU_valid && first_val_cyc < 0) first_val_cyc = cyc;
        end
        reset          = k_reset;
        IFU_stall      = k_stall;
        IDU_ready      = k_idu;
        imem_req_ready = k_rdy;
        dnpc_flag      = k_redir;
        dnpc           = k_dnpc;
        k_redir        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem(mem_addr);
        end
        if (mem_cnt > 0) mem_cnt--;
        if (k_inject) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            k_inject       = 1'b0;
        end
        #1;
        if (reset) begin
            armed = 1'b1;
            m_valid = 1'b0;
            m_pc = '0;
            npc = RPC;
            os_active = 1'b0;
            os_killed = 1'b0;
            mem_cnt = 0;
            m_fetch = '0;
            m_stall = '0;
            first_req_cyc = -1;
            first_rsp_cyc = -1;
            first_val_cyc = -1;
            idle_cyc = 0;
            return;
        end
        acc  = imem_req_valid & imem_req_ready;
        cons = IFU_valid & IDU_ready & ~IFU_stall;
        load = 1'b0;
        if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
        if (os_active || (m_valid && !cons))
            chk("req_gate", {31'b0, imem_req_valid}, 32'd0);
        else if (imem_req_valid)
            chk("req_addr", imem_req_addr, npc);
        if (cons) del_q.push_back(m_pc);
        if (imem_rsp_valid && os_active) begin
            if (!os_killed && !dnpc_flag) begin
                load = 1'b1;
                if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
            end
            os_active = 1'b0;
        end
        if (acc) begin
            os_active = 1'b1;
            os_killed = 1'b0;
            mem_addr  = imem_req_addr;
            mem_cnt   = k_lat;
            acc_q.push_back(imem_req_addr);
        end
        if (IFU_stall && m_valid) m_stall++;
        if (dnpc_flag) begin
            m_valid = 1'b0;
            npc = {dnpc[31:2], 2'b00};
            if (os_active) os_killed = 1'b1;
        end else if (load) begin
            m_valid = 1'b1;
            m_pc = npc;
            m_inst = mem(npc);
            npc = npc + 32'd4;
            m_fetch++;
        end else if (cons) begin
            m_valid = 1'b0;
        end
        if (cons) idle_cyc = 0;
        else idle_cyc++;
    endtask

    task automatic do_reset();
        k_reset = 1'b1;
        step();
        step();
        k_reset = 1'b0;
        step();
        rst_rel = cyc;
        chk("rst_valid", {31'b0, IFU_valid}, 32'd0);
        chk("rst_pc", IFU_pc, 32'd0);
        chk("rst_inst", IFU_inst, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        acc_q.delete();
        del_q.delete();
    endtask

    task automatic wait_acc(input int n);
        int c = 0;
        while (acc_q.size() < n && c < 50) begin
            step();
            c++;
        end
        if (acc_q.size() < n) chk("timeout_acc", acc_q.size(), n);
    endtask

    task automatic wait_del(input int n);
        int c = 0;
        while (del_q.size() < n && c < 50) begin
            step();
            c++;
        end
        if (del_q.size() < n) chk("timeout_del", del_q.size(), n);
    endtask

    task automatic wait_valid();
        int c = 0;
        step();
        while (!IFU_valid && c < 50) begin
            step();
            c++;
        end
        if (!IFU_valid) chk("timeout_valid", 32'd0, 32'd1);
    endtask

    initial begin
        int reqs;
        // basic streaming
        k_rdy = 1'b1;
        k_lat = 1;
        k_idu = 1'b1;
        do_reset();
        wait_del(3);
        if (del_q.size() >= 3) begin
            chk("seq_pc0", del_q[0], 32'h8000_0000);
            chk("seq_pc1", del_q[1], 32'h8000_0004);
            chk("seq_pc2", del_q[2], 32'h8000_0008);
        end
        chk("first_req_delay", first_req_cyc - rst_rel, 32'd1);
        chk("rsp_to_valid", first_val_cyc - first_rsp_cyc, 32'd1);

        // stall hold with full buffer
        k_idu = 1'b0;
        do_reset();
        wait_valid();
        k_idu = 1'b1;
        step();
        k_idu = 1'b0;
        wait_valid();
        chk("stall_pre_pc", IFU_pc, 32'h8000_0004);
        k_stall = 1'b1;
        k_idu = 1'b1;
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", IFU_pc, 32'h8000_0004);
            chk("stall_inst", IFU_inst, mem(32'h8000_0004));
            if (imem_req_valid) reqs++;
        end
        chk("stall_no_req", reqs, 32'd0);
        k_stall = 1'b0;
        step();

        // redirect in WAIT, response one cycle later
        k_lat = 2;
        do_reset();
        wait_acc(1);
        k_redir = 1'b1;
        k_dnpc = 32'h8000_0100;
        step();
        wait_acc(2);
        if (acc_q.size() >= 2) chk("kill_req_addr", acc_q[1], 32'h8000_0100);
        wait_del(1);
        if (del_q.size() >= 1) chk("kill_del_pc", del_q[0], 32'h8000_0100);

        // redirect with same-cycle response
        k_lat = 1;
        do_reset();
        wait_acc(1);
        k_redir = 1'b1;
        k_dnpc = 32'h8000_0203;
        step();
        wait_acc(2);
        if (acc_q.size() >= 2) chk("drop_req_addr", acc_q[1], 32'h8000_0200);
        wait_del(1);
        if (del_q.size() >= 1) chk("drop_del_pc", del_q[0], 32'h8000_0200);

        // pc wrap
        do_reset();
        k_redir = 1'b1;
        k_dnpc = 32'hFFFF_FFFC;
        step();
        acc_q.delete();
        wait_acc(2);
        if (acc_q.size() >= 2) begin
            chk("wrap_addr0", acc_q[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", acc_q[1], 32'h0000_0000);
        end

        // reset mid-transaction, stray response in IDLE
        k_lat = 3;
        wait_acc(acc_q.size() + 1);
        k_reset = 1'b1;
        step();
        k_reset = 1'b0;
        k_inject = 1'b1;
        step();
        acc_q.delete();
        del_q.delete();
        wait_acc(1);
        if (acc_q.size() >= 1) chk("post_rst_addr", acc_q[0], RPC);
        wait_del(1);
        if (del_q.size() >= 1) chk("post_rst_del", del_q[0], RPC);

        // redirect during IDLE
        k_reset = 1'b1;
        step();
        k_reset = 1'b0;
        k_redir = 1'b1;
        k_dnpc = 32'h8000_0041;
        step();
        acc_q.delete();
        wait_acc(1);
        if (acc_q.size() >= 1) chk("idle_redir_addr", acc_q[0], 32'h8000_0040);

`ifdef IFU_PERF_CNT_EN
        k_lat = 1;
        k_idu = 1'b0;
        do_reset();
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            k_idu = 1'b1;
            step();
            k_idu = 1'b0;
            wait_valid();
        end
        k_stall = 1'b1;
        step();
        step();
        k_stall = 1'b0;
        step();
        chk("perf_fetch_lit", perf_fetch_cnt, 32'd5);
        chk("perf_stall_lit", perf_stall_cnt, 32'd2);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            k_reset = ($urandom_range(399) == 0);
            k_stall = ($urandom_range(4) == 0);
            k_idu   = ($urandom_range(2) != 0);
            k_rdy   = ($urandom_range(3) != 0);
            k_lat   = $urandom_range(3, 1);
            k_redir = ($urandom_range(19) == 0);
            k_dnpc  = ($urandom_range(3) == 0) ?
                      (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step();
            if (idle_cyc > 300) begin
                chk("progress", idle_cyc, 32'd0);
                break;
            end
        end
        k_reset = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
